// File: rtl/de_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : de_arbiter_if
//  Purpose  : Bundles the two requester ports and the framestore port of the
//             display-engine arbiter. "slave" is the arbiter's view, "master"
//             is the view of the surrounding requesters/framestore model.
//  Revision : 1.0 - initial release
// ============================================================================
interface de_arbiter_if;
  // Requester 0
  logic        m0_req;
  logic [17:0] m0_addr;
  logic [3:0]  m0_nbyte;
  logic        m0_rnw;
  logic [31:0] m0_w_data;
  logic        m0_ack;
  logic        m0_err;
  logic [31:0] m0_r_data;
  // Requester 1
  logic        m1_req;
  logic [17:0] m1_addr;
  logic [3:0]  m1_nbyte;
  logic        m1_rnw;
  logic [31:0] m1_w_data;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] m1_r_data;
  // Framestore side
  logic        de_req;
  logic        de_ack;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic        de_rnw;
  logic [31:0] de_w_data;
  logic [31:0] de_r_data;
  // Status
  logic        busy;
  logic        grant;

  modport slave (
    input  m0_req, m0_addr, m0_nbyte, m0_rnw, m0_w_data,
    input  m1_req, m1_addr, m1_nbyte, m1_rnw, m1_w_data,
    input  de_ack, de_r_data,
    output m0_ack, m0_err, m0_r_data,
    output m1_ack, m1_err, m1_r_data,
    output de_req, de_addr, de_nbyte, de_rnw, de_w_data,
    output busy, grant
  );

  modport master (
    output m0_req, m0_addr, m0_nbyte, m0_rnw, m0_w_data,
    output m1_req, m1_addr, m1_nbyte, m1_rnw, m1_w_data,
    output de_ack, de_r_data,
    input  m0_ack, m0_err, m0_r_data,
    input  m1_ack, m1_err, m1_r_data,
    input  de_req, de_addr, de_nbyte, de_rnw, de_w_data,
    input  busy, grant
  );
endinterface
`default_nettype wire

// File: rtl/de_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : de_arbiter
//  Purpose  : Two-requester round-robin arbiter in front of a single
//             framestore port. One transaction in flight at a time, with a
//             WAIT-state timeout that aborts and reports an error.
//  Revision : 1.0 - initial release
// ============================================================================
module de_arbiter #(
  parameter int unsigned TIMEOUT = 255   // max WAIT cycles, 1..65535
) (
  input  logic          clk,
  input  logic          rst,
  de_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_RETIRE = 2'd2
  } state_t;

  // Last WAIT cycle index before abort; the counter starts at 0 on entry.
  localparam logic [15:0] c_cnt_last = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_grant;
  logic        r_last_grant;
  logic        r_busy;
  logic        r_de_req;
  logic [17:0] r_de_addr;
  logic [3:0]  r_de_nbyte;
  logic        r_de_rnw;
  logic [31:0] r_de_w_data;
  logic [1:0]  r_ack;
  logic [1:0]  r_err;
  logic [31:0] r_r_data0;
  logic [31:0] r_r_data1;

  logic        w_any_req;
  logic        w_sel;
  logic [17:0] w_addr;
  logic [3:0]  w_nbyte;
  logic        w_rnw;
  logic [31:0] w_w_data;

  // Request selection: a tie goes to whoever did not win last time.
  always_comb begin
    w_any_req = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      w_sel = ~r_last_grant;
    end else begin
      w_sel = bus.m1_req;
    end
    w_addr   = w_sel ? bus.m1_addr   : bus.m0_addr;
    w_nbyte  = w_sel ? bus.m1_nbyte  : bus.m0_nbyte;
    w_rnw    = w_sel ? bus.m1_rnw    : bus.m0_rnw;
    w_w_data = w_sel ? bus.m1_w_data : bus.m0_w_data;
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_busy       <= 1'b0;
      r_de_req     <= 1'b0;
      r_de_addr    <= '0;
      r_de_nbyte   <= '0;
      r_de_rnw     <= 1'b0;
      r_de_w_data  <= '0;
      r_ack        <= '0;
      r_err        <= '0;
      r_r_data0    <= '0;
      r_r_data1    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant      <= w_sel;
            r_last_grant <= w_sel;
            r_de_addr    <= w_addr;
            r_de_nbyte   <= w_nbyte;
            r_de_rnw     <= w_rnw;
            r_de_w_data  <= w_w_data;
            r_de_req     <= 1'b1;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A framestore ack wins over an expiring timer.
          if (bus.de_ack) begin
            r_de_req       <= 1'b0;
            r_ack[r_grant] <= 1'b1;
            r_err[r_grant] <= 1'b0;
            if (r_de_rnw) begin
              if (r_grant) begin
                r_r_data1 <= bus.de_r_data;
              end else begin
                r_r_data0 <= bus.de_r_data;
              end
            end
            r_state <= S_RETIRE;
          end else if (r_cnt == c_cnt_last) begin
            r_de_req       <= 1'b0;
            r_ack[r_grant] <= 1'b1;
            r_err[r_grant] <= 1'b1;
            r_state        <= S_RETIRE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RETIRE: begin
          // Requesters refresh req/fields during this cycle, so none are sampled.
          r_ack   <= '0;
          r_err   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.de_req    = r_de_req;
  assign bus.de_addr   = r_de_addr;
  assign bus.de_nbyte  = r_de_nbyte;
  assign bus.de_rnw    = r_de_rnw;
  assign bus.de_w_data = r_de_w_data;
  assign bus.m0_ack    = r_ack[0];
  assign bus.m1_ack    = r_ack[1];
  assign bus.m0_err    = r_err[0];
  assign bus.m1_err    = r_err[1];
  assign bus.m0_r_data = r_r_data0;
  assign bus.m1_r_data = r_r_data1;
  assign bus.busy      = r_busy;
  assign bus.grant     = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_de_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_de_arbiter
//  Purpose  : Self-checking bench for de_arbiter. The bench plays both
//             requesters and the framestore; a transaction-level model
//             predicts the winner, completion cycle, error flag and read data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_de_arbiter;

  localparam int TO = 4;

  logic clk;
  logic rst;

  de_arbiter_if bus ();

  de_arbiter #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus registers driving the interface
  logic [1:0]  t_req;
  logic [17:0] t_addr  [2];
  logic [3:0]  t_nbyte [2];
  logic        t_rnw   [2];
  logic [31:0] t_wdata [2];
  logic        t_de_ack;
  logic [31:0] t_de_rdata;

  assign bus.m0_req    = t_req[0];
  assign bus.m1_req    = t_req[1];
  assign bus.m0_addr   = t_addr[0];
  assign bus.m1_addr   = t_addr[1];
  assign bus.m0_nbyte  = t_nbyte[0];
  assign bus.m1_nbyte  = t_nbyte[1];
  assign bus.m0_rnw    = t_rnw[0];
  assign bus.m1_rnw    = t_rnw[1];
  assign bus.m0_w_data = t_wdata[0];
  assign bus.m1_w_data = t_wdata[1];
  assign bus.de_ack    = t_de_ack;
  assign bus.de_r_data = t_de_rdata;

  // Reference model state
  int          m_last;
  logic [31:0] m_rdata [2];

  int n_tests;
  int n_fail;
  int cyc;
  int ack_last;
  int ack_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record when the DUT actually pulses an ack, for spacing checks
  always @(negedge clk) begin
    if (bus.m0_ack || bus.m1_ack) begin
      ack_prev = ack_last;
      ack_last = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_fields(input int n);
    t_addr[n]  = 18'($urandom);
    t_nbyte[n] = 4'($urandom);
    t_rnw[n]   = 1'($urandom);
    t_wdata[n] = $urandom;
  endtask

  // One transaction. Entered at a negedge of an IDLE cycle with requests set.
  // k      : WAIT cycle (1-based) in which the framestore acks; k>TO = never
  // late   : requesters that raise req during WAIT (fields already set)
  // mode   : what the winner does in RETIRE: 0 drop, 1 re-request, 2 random
  // spur   : spurious de_ack during RETIRE
  // rdata  : framestore data on the ack cycle
  // drop   : winner drops req during WAIT
  task automatic do_txn(input int k, input logic [1:0] late, input int mode,
                        input bit spur, input logic [31:0] rdata, input bit drop);
    int   w;
    int   lim;
    bit   exp_err;
    if (t_req[0] && t_req[1]) w = (m_last == 0) ? 1 : 0;
    else                      w = t_req[1] ? 1 : 0;
    m_last = w;
    @(posedge clk); @(negedge clk);
    t_req = t_req | late;
    if (drop) t_req[w] = 1'b0;
    chk("grant",     32'(bus.grant),    32'(w));
    chk("de_req_on", 32'(bus.de_req),   32'd1);
    chk("busy_on",   32'(bus.busy),     32'd1);
    chk("de_addr",   32'(bus.de_addr),  32'(t_addr[w]));
    chk("de_nbyte",  32'(bus.de_nbyte), 32'(t_nbyte[w]));
    chk("de_rnw",    32'(bus.de_rnw),   32'(t_rnw[w]));
    chk("de_wdata",  bus.de_w_data,     t_wdata[w]);
    lim     = (k < TO) ? k : TO;
    exp_err = (k > TO);
    for (int c = 1; c <= lim; c++) begin
      if (c > 1) begin
        chk("wait_de_req", 32'(bus.de_req),  32'd1);
        chk("wait_addr",   32'(bus.de_addr), 32'(t_addr[w]));
      end
      t_de_ack   = (c == k);
      t_de_rdata = (c == k) ? rdata : $urandom;
      @(posedge clk); @(negedge clk);
      t_de_ack = 1'b0;
      if (c < lim) chk("no_early_ack", 32'({bus.m1_ack, bus.m0_ack}), 32'd0);
    end
    chk("ack_vec", 32'({bus.m1_ack, bus.m0_ack}), (w == 1) ? 32'd2 : 32'd1);
    chk("err", 32'(w == 1 ? bus.m1_err : bus.m0_err), 32'(exp_err));
    chk("other_err", 32'(w == 1 ? bus.m0_err : bus.m1_err), 32'd0);
    chk("de_req_off", 32'(bus.de_req), 32'd0);
    chk("busy_retire", 32'(bus.busy), 32'd1);
    if (!exp_err && t_rnw[w]) m_rdata[w] = rdata;
    chk("rdata0", bus.m0_r_data, m_rdata[0]);
    chk("rdata1", bus.m1_r_data, m_rdata[1]);
    // RETIRE cycle: requester refreshes, optional spurious framestore ack
    if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) begin
      t_req[w] = 1'b1;
      new_fields(w);
    end else begin
      t_req[w] = 1'b0;
    end
    if (spur) begin
      t_de_ack   = 1'b1;
      t_de_rdata = $urandom;
    end
    @(posedge clk); @(negedge clk);
    t_de_ack = 1'b0;
    chk("idle_ack",    32'({bus.m1_ack, bus.m0_ack}), 32'd0);
    chk("idle_err",    32'({bus.m1_err, bus.m0_err}), 32'd0);
    chk("idle_busy",   32'(bus.busy),   32'd0);
    chk("idle_de_req", 32'(bus.de_req), 32'd0);
    chk("idle_rdata0", bus.m0_r_data, m_rdata[0]);
    chk("idle_rdata1", bus.m1_r_data, m_rdata[1]);
  endtask

  // Idle cycle with a spurious framestore ack; nothing may move
  task automatic idle_spurious();
    t_de_ack   = 1'b1;
    t_de_rdata = $urandom;
    @(posedge clk); @(negedge clk);
    t_de_ack = 1'b0;
    chk("spur_busy",   32'(bus.busy),   32'd0);
    chk("spur_de_req", 32'(bus.de_req), 32'd0);
    chk("spur_ack",    32'({bus.m1_ack, bus.m0_ack}), 32'd0);
    chk("spur_rdata0", bus.m0_r_data, m_rdata[0]);
    chk("spur_rdata1", bus.m1_r_data, m_rdata[1]);
  endtask

  initial begin
    logic [1:0] late;
    n_tests = 0; n_fail = 0; cyc = 0; ack_last = 0; ack_prev = 0;
    m_last = 1; m_rdata[0] = '0; m_rdata[1] = '0;
    t_req = '0; t_de_ack = 1'b0; t_de_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      t_addr[i] = '0; t_nbyte[i] = '0; t_rnw[i] = 1'b0; t_wdata[i] = '0;
    end
    rst = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_de_req",  32'(bus.de_req),    32'd0);
    chk("rst_addr",    32'(bus.de_addr),   32'd0);
    chk("rst_nbyte",   32'(bus.de_nbyte),  32'd0);
    chk("rst_rnw",     32'(bus.de_rnw),    32'd0);
    chk("rst_wdata",   bus.de_w_data,      32'd0);
    chk("rst_ack",     32'({bus.m1_ack, bus.m0_ack}), 32'd0);
    chk("rst_err",     32'({bus.m1_err, bus.m0_err}), 32'd0);
    chk("rst_rdata0",  bus.m0_r_data,      32'd0);
    chk("rst_rdata1",  bus.m1_r_data,      32'd0);
    chk("rst_grant",   32'(bus.grant),     32'd0);
    chk("rst_busy",    32'(bus.busy),      32'd0);
    rst = 1'b0;

    // Both held, framestore acks in one cycle: grants 0,1,0,1, acks 3 apart
    new_fields(0); new_fields(1);
    t_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      do_txn(1, 2'b00, 1, 1'b0, $urandom, 1'b0);
      chk("rr_grant", 32'(bus.grant), 32'(i % 2));
      if (i > 0) chk("rr_spacing", 32'(ack_last - ack_prev), 32'd3);
    end
    t_req = 2'b00;

    // m0 read, ack two cycles into WAIT
    t_addr[0] = 18'h00010; t_nbyte[0] = 4'd4; t_rnw[0] = 1'b1; t_wdata[0] = 32'h0;
    t_req = 2'b01;
    do_txn(2, 2'b00, 0, 1'b0, 32'hDEADBEEF, 1'b0);
    chk("rd_m0_rdata", bus.m0_r_data, 32'hDEADBEEF);
    chk("rd_busy_low", 32'(bus.busy), 32'd0);

    // m1 write times out while m0 becomes pending; m0 served next
    new_fields(1); t_rnw[1] = 1'b0;
    new_fields(0);
    t_req = 2'b10;
    do_txn(TO + 3, 2'b01, 0, 1'b1, $urandom, 1'b0);
    do_txn(1, 2'b00, 0, 1'b0, $urandom, 1'b0);
    chk("to_next_grant", 32'(bus.grant), 32'd0);

    // Ack exactly on the timeout cycle completes normally
    new_fields(0); t_rnw[0] = 1'b1;
    t_req = 2'b01;
    do_txn(TO, 2'b00, 0, 1'b0, 32'h12345678, 1'b0);
    chk("edge_rdata", bus.m0_r_data, 32'h12345678);

    // Dropping req while granted still completes
    new_fields(1);
    t_req = 2'b10;
    do_txn(3, 2'b00, 0, 1'b0, $urandom, 1'b1);

    // Spurious framestore acks in IDLE
    t_req = 2'b00;
    idle_spurious();
    idle_spurious();

    // Asynchronous reset in the middle of WAIT
    new_fields(0); new_fields(1);
    t_req = 2'b11;
    @(posedge clk); @(negedge clk);
    chk("ar_pre_de_req", 32'(bus.de_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_de_req", 32'(bus.de_req), 32'd0);
    chk("ar_busy",   32'(bus.busy),   32'd0);
    chk("ar_ack",    32'({bus.m1_ack, bus.m0_ack}), 32'd0);
    chk("ar_addr",   32'(bus.de_addr), 32'd0);
    #1 rst = 1'b0;
    m_last = 1; m_rdata[0] = '0; m_rdata[1] = '0;
    do_txn(2, 2'b00, 2, 1'b0, $urandom, 1'b0);
    chk("ar_tie_m0", 32'(bus.grant), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if (t_req == 2'b00) begin
        idle_spurious();
        t_req = 2'($urandom_range(1, 3));
        if (t_req[0]) new_fields(0);
        if (t_req[1]) new_fields(1);
      end
      late = ~t_req & 2'($urandom);
      if (late[0]) new_fields(0);
      if (late[1]) new_fields(1);
      do_txn($urandom_range(1, TO + 2), late, 2, 1'($urandom),
             $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
